// File: rtl/encoder_rr_scheduler.sv
// Round-robin scheduler sharing one encoder among WIDTH requesters.
// Ports: clk, rst (sync, active-high), req, done -> grant, grant_idx, grant_valid, timeout.
module encoder_rr_scheduler #(
  parameter int WIDTH    = 4,
  parameter int IDX_W    = $clog2(WIDTH),
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req,
  input  logic             done,
  output logic [WIDTH-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid,
  output logic             timeout
);

  localparam int CNT_W = $clog2(MAX_HOLD);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_GAP
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] win_idx;
  logic             rel_own;
  logic             rel_cnt;
  logic             rel_any;

  // Search ptr, ptr+1, ... ; IDX_W-bit addition wraps modulo WIDTH.
  // Scanning downward lets the nearest candidate overwrite farther ones.
  generate
    case (WIDTH)
      2, 4, 8: begin : g_pick
        logic [IDX_W-1:0] cand;
        always_comb begin
          win_idx = '0;
          cand    = '0;
          for (int i = WIDTH - 1; i >= 0; i--) begin
            cand = ptr_q + IDX_W'(i);
            if (req[cand]) win_idx = cand;
          end
        end
      end
      default: begin : g_bad
        $error("encoder_rr_scheduler: WIDTH must be 2, 4 or 8");
        assign win_idx = '0;
      end
    endcase
  endgenerate

  // An owner dropping its request counts as done, and done beats the counter.
  assign rel_own = done | ~req[idx_q];
  assign rel_cnt = (cnt_q == CNT_W'(MAX_HOLD - 1));
  assign rel_any = rel_own | rel_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      ptr_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (|req) state_d = S_BUSY;
      S_BUSY:  if (rel_any) state_d = S_GAP;
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    grant_d   = grant_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (|req) begin
          grant_d = WIDTH'(1) << win_idx;
          idx_d   = win_idx;
          valid_d = 1'b1;
          cnt_d   = '0;
        end
      end
      S_BUSY: begin
        if (rel_any) begin
          grant_d   = '0;
          idx_d     = '0;
          valid_d   = 1'b0;
          timeout_d = rel_cnt & ~rel_own;
          ptr_d     = idx_q + IDX_W'(1);
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        grant_d = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  assign grant       = grant_q;
  assign grant_idx   = idx_q;
  assign grant_valid = valid_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_encoder_rr_scheduler.sv
// Testbench for encoder_rr_scheduler: directed vectors plus a cycle model.
// Instances at WIDTH=4 (model-checked) and WIDTH=8 (literal checks).
module tb_encoder_rr_scheduler;

  localparam int W  = 4;
  localparam int MH = 8;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic [3:0] req   = '0;
  logic       done  = 1'b0;
  logic [3:0] grant;
  logic [1:0] gidx;
  logic       gv;
  logic       to;

  logic [7:0] req8  = '0;
  logic       done8 = 1'b0;
  logic [7:0] grant8;
  logic [2:0] gidx8;
  logic       gv8;
  logic       to8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  encoder_rr_scheduler #(.WIDTH(W), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .grant(grant), .grant_idx(gidx),
    .grant_valid(gv), .timeout(to)
  );

  encoder_rr_scheduler #(.WIDTH(8), .MAX_HOLD(MH)) dut8 (
    .clk(clk), .rst(rst), .req(req8), .done(done8),
    .grant(grant8), .grant_idx(gidx8),
    .grant_valid(gv8), .timeout(to8)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Model: owner (-1 = none), cycles owned, pending gap, next priority.
  int m_own = -1;
  int m_age = 0;
  int m_ptr = 0;
  bit m_gap = 0;
  bit m_to  = 0;
  bit m_en  = 0;
  bit m_d;
  bit m_t;

  always @(posedge clk) begin
    if (rst) begin
      m_own = -1; m_age = 0; m_ptr = 0;
      m_gap = 0;  m_to  = 0; m_en  = 1;
    end else if (m_own >= 0) begin
      m_d = done || !req[m_own];
      m_t = (m_age == MH - 1);
      if (m_d || m_t) begin
        m_to  = m_t && !m_d;
        m_ptr = (m_own + 1) % W;
        m_own = -1;
        m_gap = 1;
      end else begin
        m_age++;
        m_to = 0;
      end
    end else if (m_gap) begin
      m_gap = 0;
      m_to  = 0;
    end else begin
      m_to = 0;
      for (int k = 0; k < W; k++) begin
        if (m_own < 0 && req[(m_ptr + k) % W]) begin
          m_own = (m_ptr + k) % W;
          m_age = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_en) begin
      chk("mdl_grant", grant, (m_own >= 0) ? (32'd1 << m_own) : 32'd0);
      chk("mdl_valid", gv, (m_own >= 0) ? 32'd1 : 32'd0);
      chk("mdl_timeout", to, m_to);
      if (m_own >= 0) chk("mdl_idx", gidx, m_own);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int seq4 [4] = '{1, 2, 3, 0};

  initial begin
    // reset with all requests pending
    rst = 1'b1; req = 4'b1111;
    step(3);
    chk("t1_grant", grant, 0);
    chk("t1_valid", gv, 0);
    chk("t1_idx", gidx, 0);
    chk("t1_timeout", to, 0);
    rst = 1'b0;
    step(1);
    chk("t1_first_idx", gidx, 0);
    chk("t1_first_valid", gv, 1);
    req = 4'b0000;
    step(1);
    chk("t1_drop_valid", gv, 0);
    step(1);

    // single request, done at cycle 3
    req = 4'b0010;
    step(1);
    chk("t2_grant", grant, 4'b0010);
    chk("t2_idx", gidx, 1);
    chk("t2_valid", gv, 1);
    step(2);
    done = 1'b1;
    step(1);
    done = 1'b0;
    chk("t2_rel_grant", grant, 0);
    chk("t2_rel_timeout", to, 0);
    step(2);
    chk("t2_regrant_idx", gidx, 1);

    // requester drop, then reset mid-grant
    req = 4'b0000;
    step(1);
    chk("t5_drop_valid", gv, 0);
    chk("t5_drop_timeout", to, 0);
    step(1);
    req = 4'b1000;
    step(1);
    chk("t5_idx3", gidx, 3);
    rst = 1'b1;
    step(1);
    chk("t5_rst_grant", grant, 0);
    chk("t5_rst_valid", gv, 0);
    rst = 1'b0; req = 4'b1111;
    step(1);
    chk("t5_ptr0_idx", gidx, 0);

    // fairness rotation with wrap
    foreach (seq4[i]) begin
      done = 1'b1;
      step(1);
      done = 1'b0;
      step(2);
      chk("t3_rr_idx", gidx, seq4[i]);
    end

    // hold timeout
    req = 4'b0000;
    step(2);
    req = 4'b0100;
    step(1);
    chk("t4_idx", gidx, 2);
    for (int i = 0; i < 7; i++) begin
      step(1);
      chk("t4_hold_valid", gv, 1);
    end
    step(1);
    chk("t4_to_valid", gv, 0);
    chk("t4_to_pulse", to, 1);
    step(1);
    chk("t4_to_end", to, 0);
    step(1);
    chk("t4_regrant_idx", gidx, 2);
    step(7);
    done = 1'b1;
    step(1);
    done = 1'b0;
    chk("t4_done_wins_valid", gv, 0);
    chk("t4_done_wins_to", to, 0);
    req = 4'b0000;
    step(2);

    // WIDTH=8: req=0x81 rotates 0 -> 7 -> 0
    req8 = 8'h81;
    step(1);
    chk("t6_w8_idx0", gidx8, 0);
    chk("t6_w8_grant0", grant8, 8'h01);
    done8 = 1'b1;
    step(1);
    done8 = 1'b0;
    step(2);
    chk("t6_w8_idx7", gidx8, 7);
    chk("t6_w8_grant7", grant8, 8'h80);
    done8 = 1'b1;
    step(1);
    done8 = 1'b0;
    step(2);
    chk("t6_w8_wrap_idx", gidx8, 0);
    req8 = 8'h00;
    step(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
